// File: rtl/wbc_kw11l_if.sv
// Bus-side bundle for the KW11-L line clock.
// It carries the Wishbone slave port and the interrupt request/acknowledge pair.
interface wbc_kw11l_if;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [1:0]  wb_sel_i;
   logic [15:0] wb_dat_i;
   logic [15:0] wb_dat_o;
   logic        wb_ack_o;
   logic        irq_o;
   logic        iack_i;
   logic [8:0]  ivec_o;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i, iack_i,
      output wb_dat_o, wb_ack_o, irq_o, ivec_o
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i, iack_i,
      input  wb_dat_o, wb_ack_o, irq_o, ivec_o
   );
endinterface

// File: rtl/wbc_kw11l.sv
// KW11-L compatible line-time clock: it detects rising edges of the 50 Hz tick,
// keeps the MON/IE CSR, and holds a single vectored interrupt request.
module wbc_kw11l #(
   parameter logic [8:0] VECTOR = 9'o100
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic sys_init,
   input  logic tick_i,
   input  logic lks_ena,
   wbc_kw11l_if.slave bus
);

   logic        tick_q;
   logic        mon;
   logic        ie;
   logic        irq;
   logic        ack;
   logic [15:0] rdata;

   logic access;
   logic csr_wr;
   logic tick_ev;

   assign access  = bus.wb_cyc_i & bus.wb_stb_i & ~ack;
   assign csr_wr  = access & bus.wb_we_i & bus.wb_sel_i[0];
   assign tick_ev = tick_i & ~tick_q & lks_ena;

   // tick_q resets high so a tick level already present at reset release is not an edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tick_q <= 1'b1;
         mon    <= 1'b0;
         ie     <= 1'b0;
         irq    <= 1'b0;
         ack    <= 1'b0;
         rdata  <= 16'h0000;
      end else if (sys_init) begin
         tick_q <= tick_i;
         mon    <= 1'b0;
         ie     <= 1'b0;
         irq    <= 1'b0;
         ack    <= 1'b0;
         rdata  <= 16'h0000;
      end else begin
         tick_q <= tick_i;
         ack    <= access;
         rdata  <= access ? {8'b0, mon, ie, 6'b0} : 16'h0000;

         if (tick_ev)
            mon <= 1'b1;
         else if (csr_wr && !bus.wb_dat_i[7])
            mon <= 1'b0;

         if (csr_wr)
            ie <= bus.wb_dat_i[6];

         // Disabling IE beats a new tick, and a new tick beats an acknowledge.
         if (csr_wr && !bus.wb_dat_i[6])
            irq <= 1'b0;
         else if (tick_ev && ie)
            irq <= 1'b1;
         else if (bus.iack_i)
            irq <= 1'b0;
      end
   end

   assign bus.wb_ack_o = ack;
   assign bus.wb_dat_o = rdata;
   assign bus.irq_o    = irq;
   assign bus.ivec_o   = VECTOR;

endmodule

// File: doc/wbc_kw11l.md
# wbc_kw11l

Line-time clock (KW11-L compatible) for the system bus, sitting directly downstream of the reset/timer generator. It consumes the 50 Hz timer square wave (`sys_irq`) and bus-init, exposes the 16-bit CSR at 177546 over a Wishbone slave port, and raises a vectored interrupt request toward the CPU's interrupt arbiter with a request/acknowledge handshake.

## Interface
- `VECTOR`, 9'o100, interrupt vector presented on `ivec_o`.
- `sys_clk` in 1: system clock; all logic is synchronous to its rising edge.
- `sys_rst_n` in 1: reset, asynchronous and active-low.
- `sys_init` in 1: synchronous bus INIT (DCLO/RESET instruction); clears like reset when high.
- `tick_i` in 1: 50 Hz timer level from the reset generator, same clock domain.
- `lks_ena` in 1: front-panel clock enable; 0 masks ticks.
- `wb_cyc_i` in 1, `wb_stb_i` in 1: bus cycle/strobe; an external decoder asserts `wb_stb_i` only for address 177546.
- `wb_we_i` in 1: write enable.
- `wb_sel_i` in 2: byte selects.
- `wb_dat_i` in 16: write data.
- `wb_dat_o` out 16: read data.
- `wb_ack_o` out 1: cycle acknowledge.
- `irq_o` out 1: interrupt request, level, held until acknowledged.
- `iack_i` in 1: interrupt acknowledge, one-cycle pulse from the arbiter.
- `ivec_o` out 9: interrupt vector, constant `VECTOR`.

## Operation
- CSR layout: bit 7 MON (tick monitor), bit 6 IE (interrupt enable), all other bits read 0, writes to them ignored.
- Tick detect: `tick_q` registers `tick_i` every cycle; a tick event is `tick_i & ~tick_q & lks_ena`. This is exactly one event per timer period, on the rising edge.
- MON: set to 1 on a tick event. A write with `wb_sel_i[0]=1` and `wb_dat_i[7]=0` clears it. Writing 1 to bit 7 has no effect.
- IE: a write with `wb_sel_i[0]=1` loads `wb_dat_i[6]`. `wb_sel_i[0]=0` leaves both bits unchanged. `wb_sel_i[1]` is don't-care.
- Request state (`irq_o`):
  - Set on a tick event when IE=1, evaluated with the IE value before any same-cycle write.
  - Cleared when `iack_i=1`, or when a write loads IE=0.
  - At most one request is pending; a tick while `irq_o=1` is absorbed, and MON stays 1.
- Wishbone access: `cyc & stb & ~wb_ack_o` is an access cycle.
  - `wb_ack_o` goes 1 on the next edge and drops on the edge after, so each access gets exactly one ack pulse.
  - The write commits on the same edge that raises `wb_ack_o`.
  - `wb_dat_o` is registered on that edge as {8'b0, MON, IE, 6'b0} of the pre-write value. It holds 0 when not acknowledging.
- Same-cycle priorities:
  - Reset > `sys_init` > everything else.
  - Tick event vs write clearing MON: MON ends 1.
  - Tick event vs write IE=0: irq_o ends 0 and IE ends 0.
  - Tick event vs write IE 0→1: no request; IE ends 1.
  - Tick event (IE=1) vs `iack_i`: irq_o ends 1, because the new request wins.
  - `iack_i` while `irq_o=0` is ignored.
- `sys_init=1` clears MON, IE, `irq_o` and `wb_ack_o`, and sets `tick_q<=tick_i`, so no tick event is produced while init is asserted or in the cycle it releases.

## Timing
- Reset values:
  - `wb_ack_o` 0, `wb_dat_o` 0, `irq_o` 0, MON 0, IE 0.
  - `tick_q` 1, so a high `tick_i` at reset release produces no spurious event.
  - `ivec_o` = `VECTOR` always.
- Tick → MON/`irq_o`: both visible 1 cycle after the edge where `tick_i` first reads 1.
- Bus: ack latency is 1 cycle. Minimum back-to-back access period is 2 cycles.
- `iack_i` → `irq_o` low on the next cycle.
- Reset mid-access: `wb_ack_o` drops asynchronously; the write is lost if it has not yet committed.

## Test plan
- Reset release with `tick_i=1`, hold 10 cycles → MON=0, `irq_o=0`. Read CSR → `wb_dat_o`=0, ack for exactly 1 cycle.
- Write 16'o100 (IE=1), then raise `tick_i` → one cycle later `irq_o=1`, CSR reads 16'o300, `ivec_o`=9'o100. Pulse `iack_i` → `irq_o=0` next cycle, CSR still reads 16'o300.
- IE=1 with `irq_o=1` pending, second tick before ack → still a single request; one `iack_i` clears it. Then write 16'o100 → CSR reads 16'o100, since MON was cleared and IE kept.
- Same-cycle collisions:
  - Tick edge coincident with `iack_i` → `irq_o` stays 1.
  - Tick edge coincident with write 16'o0 → MON=1, IE=0, `irq_o=0`.
- `lks_ena=0`, three tick periods → MON stays 0. Set `lks_ena=1` while `tick_i` is already high → no event until the next rising edge.
- `sys_init` pulse while `irq_o=1`, IE=1, MON=1 → all clear next cycle. Releasing init with `tick_i=1` produces no event.
